uart_rx: RTL and testbench

- 8N1 asynchronous serial receiver. It is the receive-side counterpart of the team's UART transmitter, and it accepts bytes from an external host or loopback line.
- It oversamples the line at OVERSAMPLE x baud, rejects start-bit glitches and checks the stop bit.
- Each received byte is presented on a valid/ack holding register to downstream logic, such as a preset or command decoder feeding the ring-oscillator counter.

---
 rtl/uart_rx.sv | 148 ++++++++++++++
 tb/tb_uart_rx.sv | 336 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx.sv
// 8N1 UART receiver, OVERSAMPLE x baud, mid-bit sampling.
// Glitch-filtered start, stop-bit check, valid/ack holding register.
module uart_rx #(
  parameter int SERIAL_COMM = 115200,
  parameter int CLK_SPEED   = 100_000_000,
  parameter int OVERSAMPLE  = 16,
  parameter int DIV         = CLK_SPEED / (SERIAL_COMM * OVERSAMPLE)
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  input  logic       rx,
  input  logic       rx_ack,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       rx_busy,
  output logic       frame_err,
  output logic       overrun
);

  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int SW = $clog2(OVERSAMPLE);
  localparam logic [CW-1:0] CMAX = CW'(DIV - 1);
  localparam logic [SW-1:0] HALF = SW'(OVERSAMPLE / 2 - 1);
  localparam logic [SW-1:0] LAST = SW'(OVERSAMPLE - 1);

  typedef enum logic [2:0] {
    IDLE, START, DATA, STOP, BRK
  } state_t;

  state_t        state;
  logic          sync1;
  logic          rx_s;
  logic [CW-1:0] cnt;
  logic [SW-1:0] scnt;
  logic [2:0]    idx;
  logic [7:0]    shift;
  logic          tick;

  assign tick = (cnt == CMAX);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      sync1     <= 1'b1;
      rx_s      <= 1'b1;
      cnt       <= '0;
      scnt      <= '0;
      idx       <= '0;
      shift     <= '0;
      rx_data   <= '0;
      rx_valid  <= 1'b0;
      rx_busy   <= 1'b0;
      frame_err <= 1'b0;
      overrun   <= 1'b0;
    end else if (!en) begin
      state     <= IDLE;
      sync1     <= 1'b1;
      rx_s      <= 1'b1;
      cnt       <= '0;
      scnt      <= '0;
      idx       <= '0;
      shift     <= '0;
      rx_valid  <= 1'b0;
      rx_busy   <= 1'b0;
      frame_err <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      sync1     <= rx;
      rx_s      <= sync1;
      frame_err <= 1'b0;
      overrun   <= 1'b0;
      cnt       <= tick ? '0 : cnt + CW'(1);
      if (rx_ack)
        rx_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (tick && !rx_s) begin
            state   <= START;
            scnt    <= '0;
            rx_busy <= 1'b1;
          end
        end
        START: begin
          if (tick) begin
            if (scnt == HALF) begin
              scnt <= '0;
              idx  <= '0;
              if (!rx_s) begin
                state <= DATA;
              end else begin
                state   <= IDLE;
                rx_busy <= 1'b0;
              end
            end else begin
              scnt <= scnt + SW'(1);
            end
          end
        end
        DATA: begin
          if (tick) begin
            if (scnt == LAST) begin
              shift[idx] <= rx_s;
              scnt       <= '0;
              if (idx == 3'd7)
                state <= STOP;
              else
                idx <= idx + 3'd1;
            end else begin
              scnt <= scnt + SW'(1);
            end
          end
        end
        STOP: begin
          if (tick) begin
            if (scnt == LAST) begin
              scnt <= '0;
              if (rx_s) begin
                rx_data  <= shift;
                rx_valid <= 1'b1;
                overrun  <= rx_valid && !rx_ack;
                state    <= IDLE;
                rx_busy  <= 1'b0;
              end else begin
                frame_err <= 1'b1;
                state     <= BRK;
              end
            end else begin
              scnt <= scnt + SW'(1);
            end
          end
        end
        BRK: begin
          // a held-low line must go idle before a new start is accepted
          if (rx_s) begin
            state   <= IDLE;
            rx_busy <= 1'b0;
          end
        end
        default: begin
          state   <= IDLE;
          rx_busy <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
// Bench for uart_rx: vector table, random bytes/bauds, corner sequences.
// Expected landing edges come from a tick-phase model of the receiver.
module tb_uart_rx;

  localparam int CLK_HZ = 1_600_000;
  localparam int BAUD   = 10_000;
  localparam int OS     = 16;
  localparam int DIV    = 10;
  // stop-bit centre is 9.5 bit periods after start detection
  localparam int LAND   = 19 * OS * DIV / 2;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       en = 1'b0;
  logic       rx = 1'b1;
  logic       rx_ack = 1'b0;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_busy;
  logic       frame_err;
  logic       overrun;

  uart_rx #(
    .SERIAL_COMM(BAUD),
    .CLK_SPEED  (CLK_HZ),
    .OVERSAMPLE (OS)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .en       (en),
    .rx       (rx),
    .rx_ack   (rx_ack),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .rx_busy  (rx_busy),
    .frame_err(frame_err),
    .overrun  (overrun)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_chk = 0;
  int n_fail = 0;
  int rel = 0;
  int pred_start, pred_det, pred_land;

  logic pv = 1'b0;
  int rise_cyc = -1;
  int err_cnt = 0;
  int err_cyc = -1;
  int ovr_cnt = 0;
  int ovr_cyc = -1;
  int low_run = 0;
  int last_gap = -1;

  always @(negedge clk) begin
    if (rx_valid === 1'b1 && !pv) rise_cyc = cyc;
    pv = (rx_valid === 1'b1);
    if (frame_err === 1'b1) begin
      err_cnt++;
      err_cyc = cyc;
    end
    if (overrun === 1'b1) begin
      ovr_cnt++;
      ovr_cyc = cyc;
    end
    if (rx_busy !== 1'b1) begin
      low_run++;
    end else begin
      if (low_run > 0) last_gap = low_run;
      low_run = 0;
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wait_to(input int n);
    while (cyc < n) begin
      @(posedge clk);
      #1;
    end
  endtask

  function automatic int next_tick(input int n);
    int m;
    m = n;
    while (m <= rel || ((m - rel) % DIV) != 0) m++;
    return m;
  endfunction

  task automatic send(input logic [7:0] d, input logic stop,
                      input int baud);
    logic [9:0] fr;
    int e;
    e = cyc;
    fr = {stop, d, 1'b0};
    pred_start = e;
    pred_det   = next_tick(e + 3);
    pred_land  = pred_det + LAND;
    for (int k = 0; k < 10; k++) begin
      rx = fr[k];
      wait_to(e + ((k + 1) * CLK_HZ + baud / 2) / baud);
    end
  endtask

  task automatic rx_byte(input string nm, input logic [7:0] d,
                         input int baud, input logic [7:0] exp_d,
                         input bit do_ack);
    int e0;
    int lat;
    step($urandom_range(0, 25));
    e0 = err_cnt;
    send(d, 1'b1, baud);
    lat = rise_cyc - pred_start;
    chk({nm, " data"}, rx_data, exp_d);
    chk({nm, " valid"}, rx_valid, 1);
    chk({nm, " land"}, rise_cyc, pred_land);
    chk({nm, " lat"}, (lat >= 1520 && lat <= 1532), 1);
    chk({nm, " ferr"}, err_cnt - e0, 0);
    if (do_ack) begin
      rx_ack = 1'b1;
      step(1);
      rx_ack = 1'b0;
      chk({nm, " ack"}, rx_valid, 0);
    end
  endtask

  typedef struct {
    logic [7:0] d;
    int         baud;
    logic [7:0] exp_d;
  } vec_t;

  vec_t tbl[6];
  logic [7:0] got[$];
  logic [7:0] b2b[3];

  initial begin
    int e, det, l1, l2, e0, o0, bd;
    logic [7:0] rb;

    tbl[0] = '{8'hA5, 10_000, 8'hA5};
    tbl[1] = '{8'h55, 10_300, 8'h55};
    tbl[2] = '{8'hAA, 10_300, 8'hAA};
    tbl[3] = '{8'h55,  9_700, 8'h55};
    tbl[4] = '{8'hAA,  9_700, 8'hAA};
    tbl[5] = '{8'h01, 10_000, 8'h01};
    b2b[0] = 8'h00;
    b2b[1] = 8'hFF;
    b2b[2] = 8'h3C;

    step(3);
    chk("rst data", rx_data, 0);
    chk("rst valid", rx_valid, 0);
    chk("rst busy", rx_busy, 0);
    chk("rst ferr", frame_err, 0);
    chk("rst ovr", overrun, 0);
    rst_n = 1'b1;
    en = 1'b1;
    rel = cyc;
    step(20);

    for (int i = 0; i < 6; i++)
      rx_byte($sformatf("vec%0d", i), tbl[i].d, tbl[i].baud,
              tbl[i].exp_d, 1'b1);

    for (int i = 0; i < 4; i++) begin
      rb = 8'($urandom);
      bd = $urandom_range(9_700, 10_300);
      rx_byte($sformatf("rnd%0d", i), rb, bd, rb, 1'b1);
    end

    // back-to-back frames, consumer acks each byte as it lands
    step(20);
    fork
      begin
        send(b2b[0], 1'b1, BAUD);
        l1 = pred_land;
        send(b2b[1], 1'b1, BAUD);
        chk("b2b gap1", last_gap, pred_det - l1);
        l2 = pred_land;
        send(b2b[2], 1'b1, BAUD);
        chk("b2b gap2", last_gap, pred_det - l2);
      end
      begin
        for (int i = 0; i < 3; i++) begin
          int t;
          t = 0;
          while (rx_valid !== 1'b1 && t < 3000) begin
            step(1);
            t++;
          end
          if (t >= 3000) chk("b2b timeout", 0, 1);
          got.push_back(rx_data);
          rx_ack = 1'b1;
          step(1);
          rx_ack = 1'b0;
        end
      end
    join
    for (int i = 0; i < 3; i++)
      chk($sformatf("b2b byte%0d", i), got[i], b2b[i]);

    // start-bit glitch of 40 clk
    step(20);
    e = cyc;
    det = next_tick(e + 3);
    rx = 1'b0;
    step(40);
    rx = 1'b1;
    wait_to(det + 79);
    chk("glitch busy", rx_busy, 1);
    wait_to(det + 80);
    chk("glitch idle", rx_busy, 0);
    chk("glitch valid", rx_valid, 0);
    step(20);
    rx_byte("after glitch", 8'h5A, BAUD, 8'h5A, 1'b1);

    // bad stop bit followed by a 3-bit break
    step(20);
    e0 = err_cnt;
    send(8'h81, 1'b0, BAUD);
    chk("ferr count", err_cnt - e0, 1);
    chk("ferr edge", err_cyc, pred_land);
    chk("ferr valid", rx_valid, 0);
    step(480);
    chk("break busy", rx_busy, 1);
    chk("break ferr", err_cnt - e0, 1);
    chk("break valid", rx_valid, 0);
    rx = 1'b1;
    step(4);
    chk("break end", rx_busy, 0);
    step(20);
    rx_byte("after break", 8'h42, BAUD, 8'h42, 1'b1);

    // overrun, then ack colliding with a landing byte
    step(20);
    o0 = ovr_cnt;
    send(8'h11, 1'b1, BAUD);
    step(20);
    send(8'h22, 1'b1, BAUD);
    chk("ovr count", ovr_cnt - o0, 1);
    chk("ovr edge", ovr_cyc, pred_land);
    chk("ovr data", rx_data, 8'h22);
    chk("ovr valid", rx_valid, 1);
    step(20);
    fork
      send(8'h33, 1'b1, BAUD);
      begin
        step(1);
        wait_to(pred_land - 1);
        rx_ack = 1'b1;
        step(1);
        rx_ack = 1'b0;
      end
    join
    chk("coll ovr", ovr_cnt - o0, 1);
    chk("coll valid", rx_valid, 1);
    chk("coll data", rx_data, 8'h33);
    rx_ack = 1'b1;
    step(1);
    rx_ack = 1'b0;
    chk("coll ack", rx_valid, 0);

    // async reset during bit 4 with an unconsumed byte held
    rx_byte("pre rst", 8'h77, BAUD, 8'h77, 1'b0);
    step(20);
    fork
      send(8'hC3, 1'b1, BAUD);
      begin
        step(1);
        wait_to(pred_start + 5 * OS * DIV + 20);
        chk("rst mid busy", rx_busy, 1);
        rst_n = 1'b0;
        #1;
        chk("rst mid data", rx_data, 0);
        chk("rst mid valid", rx_valid, 0);
        chk("rst mid busy0", rx_busy, 0);
      end
    join
    step(5);
    rst_n = 1'b1;
    rel = cyc;
    step(20);
    rx_byte("after rst", 8'h99, BAUD, 8'h99, 1'b0);

    // enable drop during bit 4 keeps rx_data
    step(20);
    fork
      send(8'hC3, 1'b1, BAUD);
      begin
        step(1);
        wait_to(pred_start + 5 * OS * DIV + 20);
        chk("en mid busy", rx_busy, 1);
        en = 1'b0;
        step(1);
        chk("en data", rx_data, 8'h99);
        chk("en valid", rx_valid, 0);
        chk("en busy", rx_busy, 0);
      end
    join
    step(5);
    en = 1'b1;
    rel = cyc;
    step(20);
    rx_byte("after en", 8'h66, BAUD, 8'h66, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
